// File: rtl/and_or_pipe.sv
// and_or_pipe: pipelined (in1 & in2) | in3 with PASS/INV/ACC/LOAD modes.
// Ports: clk, reset, in_valid, in1..in3, mode -> out_valid, out, acc, hit_count.
module and_or_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      hit_count
);

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_INV  = 2'b01;
  localparam logic [1:0] M_ACC  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_acc_we;
  logic             w_hit;

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_dat [STAGES];
  logic [WIDTH-1:0]  r_acc;
  logic [15:0]       r_hit;

  assign w_f = (in1 & in2) | in3;

  always_comb begin
    w_r       = w_f;
    w_acc_nxt = r_acc;
    w_acc_we  = 1'b0;
    unique case (mode)
      M_PASS: w_r = w_f;
      M_INV:  w_r = ~w_f;
      M_ACC: begin
        w_r       = r_acc | w_f;
        w_acc_nxt = r_acc | w_f;
        w_acc_we  = in_valid;
      end
      M_LOAD: begin
        w_r       = w_f;
        w_acc_nxt = w_f;
        w_acc_we  = in_valid;
      end
      default: w_r = w_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++)
        r_dat[i] <= '0;
    end else begin
      r_vld[0] <= in_valid;
      if (in_valid)
        r_dat[0] <= w_r;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1])
          r_dat[i] <= r_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_acc <= '0;
    else if (w_acc_we)
      r_acc <= w_acc_nxt;
  end

  // Count all-ones results leaving the pipe; stick at the top value.
  assign w_hit = r_vld[STAGES-1] && (&r_dat[STAGES-1]);

  always_ff @(posedge clk) begin
    if (reset)
      r_hit <= '0;
    else if (w_hit && (r_hit != 16'hFFFF))
      r_hit <= r_hit + 16'd1;
  end

  assign out_valid = r_vld[STAGES-1];
  assign out       = r_dat[STAGES-1];
  assign acc       = r_acc;
  assign hit_count = r_hit;

endmodule

// File: tb/tb_and_or_pipe.sv
// tb_and_or_pipe: directed scoreboard bench for and_or_pipe.
// Expected results are queued at drive time and checked on output.
module tb_and_or_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in1, in2, in3;
  logic [1:0]   mode;
  logic         out_valid;
  logic [W-1:0] out;
  logic [W-1:0] acc;
  logic [15:0]  hit_count;

  and_or_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .mode(mode),
    .out_valid(out_valid), .out(out), .acc(acc),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] m_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("stray_valid", 32'(out), 32'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(out), 32'(e.d));
        chk("out_cycle", cyc, e.c);
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] m,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input bit push);
    logic [W-1:0] f, r;
    exp_t e;
    in_valid = v; mode = m; in1 = a; in2 = b; in3 = c;
    f = (a & b) | c;
    r = f;
    if (v) begin
      case (m)
        2'b01: r = ~f;
        2'b10: begin r = m_acc | f; m_acc = r; end
        2'b11: begin r = f; m_acc = f; end
        default: r = f;
      endcase
      if (push) begin
        e.d = r;
        e.c = cyc + S;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    mode = 2'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    idle(S + 2);
    chk(tag, q.size(), 0);
  endtask

  initial begin
    m_acc = '0;
    reset = 1'b1;
    in_valid = 1'b1;
    in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    mode = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_out", 32'(out), 0);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_hit", 32'(hit_count), 0);
      in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
      mode = 2'($urandom);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rel_ov", 32'(out_valid), 0);
    chk("rel_out", 32'(out), 0);
    chk("rel_acc", 32'(acc), 0);
    chk("rel_hit", 32'(hit_count), 0);

    // PASS then INV
    step(1'b1, 2'b00, 8'hF0, 8'h3C, 8'h01, 1'b1);
    idle(3);
    step(1'b1, 2'b01, 8'hF0, 8'h3C, 8'h01, 1'b1);
    drain("drain_inv");
    chk("hold_out", 32'(out), 32'hCE);
    chk("hold_ov", 32'(out_valid), 0);
    chk("pass_acc", 32'(acc), 0);

    // accumulate chain, load, accumulate
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h01, 1'b1);
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h02, 1'b1);
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h04, 1'b1);
    chk("acc_07", 32'(acc), 32'h07);
    step(1'b1, 2'b11, 8'h00, 8'h00, 8'h10, 1'b1);
    chk("acc_10", 32'(acc), 32'h10);
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h01, 1'b1);
    chk("acc_11", 32'(acc), 32'h11);
    drain("drain_acc");
    chk("acc_hit0", 32'(hit_count), 0);

    // bubbles and hits
    step(1'b1, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b1);
    step(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b1);
    step(1'b1, 2'b00, 8'h00, 8'h00, 8'h0F, 1'b1);
    drain("drain_bub");
    chk("bub_hit2", 32'(hit_count), 2);
    chk("bub_out", 32'(out), 32'h0F);

    // reset while an ACC result is in flight
    step(1'b1, 2'b10, 8'h00, 8'h00, 8'h55, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_acc = '0;
    chk("mid_acc", 32'(acc), 0);
    chk("mid_out", 32'(out), 0);
    chk("mid_hit", 32'(hit_count), 0);
    drain("drain_mid");
    chk("mid_ov", 32'(out_valid), 0);
    chk("mid_acc2", 32'(acc), 0);

    // saturation
    for (int i = 0; i < 65535; i++)
      step(1'b1, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b1);
    drain("drain_sat0");
    chk("sat_ffff", 32'(hit_count), 32'hFFFF);
    step(1'b1, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b1);
    step(1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
    drain("drain_sat1");
    chk("sat_hold", 32'(hit_count), 32'hFFFF);
    chk("sat_acc", 32'(acc), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
